// File: rtl/local_pred_bank_pkg.sv
// Shared branch predictor definitions: 2-bit counter encoding, reset value,
// history selector width and bank count. The global history register sizes
// its selector output from HIST_W so both sides stay in step.
package local_pred_bank_pkg;

  localparam logic [1:0] CNT_SU = 2'b00;  // strongly untaken
  localparam logic [1:0] CNT_WU = 2'b01;  // weakly untaken
  localparam logic [1:0] CNT_WT = 2'b10;  // weakly taken
  localparam logic [1:0] CNT_ST = 2'b11;  // strongly taken

  localparam logic [1:0] CNT_RESET = CNT_WU;

  localparam int HIST_W    = 2;
  localparam int NUM_BANKS = 1 << HIST_W;

  // Next counter value for a resolved direction, saturating at both ends.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    end else begin
      return (cnt == CNT_SU) ? CNT_SU : cnt - 2'd1;
    end
  endfunction

endpackage

// File: rtl/local_pred_bank_sat_counter2.sv
// One 2-bit saturating direction counter; one instance per table entry.
module sat_counter2
  import local_pred_bank_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       taken_i,
  output logic [1:0] count_o
);

  // Train toward the resolved direction when enabled; reset to weakly untaken.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= CNT_RESET;
    end else if (en_i) begin
      count_o <= cnt_next(count_o, taken_i);
    end
  end

endmodule

// File: rtl/local_pred_bank.sv
// Local branch direction predictor: NUM_BANKS banks of 2-bit saturating
// counters, one bank per global history pattern. Fetch reads combinationally,
// Execute trains the entry addressed by the branch's own history and PC.
// Build option: define PRED_BYPASS_EN to forward a same-cycle update to a
// matching Fetch read; otherwise that read sees the stored pre-update value.
module local_pred_bank
  import local_pred_bank_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       pc_f_i,
  input  logic [HIST_W-1:0] local_src_i,
  output logic              pred_taken_f_o,
  input  logic [31:0]       pc_e_i,
  input  logic [HIST_W-1:0] local_src_e_i,
  input  logic [1:0]        branch_op_e_i,
  input  logic              pc_src_res_e_i,
  input  logic              stall_e_i
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [HIST_W-1:0]     rd_bank;
  logic [HIST_W-1:0]     wr_bank;
  logic                  upd;
  logic [1:0]            rd_cnt;
  logic [1:0]            cnt [NUM_BANKS][ENTRIES];

  assign rd_idx  = pc_f_i[INDEX_BITS+1:2];
  assign wr_idx  = pc_e_i[INDEX_BITS+1:2];
  assign rd_bank = local_src_i;
  assign wr_bank = local_src_e_i;

  // Only conditional branches train; unconditional flow (op bit 1) never does.
  assign upd = branch_op_e_i[0] & ~stall_e_i;

  // Word-offset and high PC bits are deliberately dropped (aliasing is accepted).
  logic unused_ok;
  assign unused_ok = &{1'b0, pc_f_i[31:INDEX_BITS+2], pc_f_i[1:0],
                       pc_e_i[31:INDEX_BITS+2], pc_e_i[1:0], branch_op_e_i[1]};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
      logic wr_en;
      assign wr_en = upd && (wr_bank == HIST_W'(b)) && (wr_idx == INDEX_BITS'(e));

      sat_counter2 u_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (wr_en),
        .taken_i (pc_src_res_e_i),
        .count_o (cnt[b][e])
      );
    end
  end

  assign rd_cnt = cnt[rd_bank][rd_idx];

`ifdef PRED_BYPASS_EN
  logic [1:0] byp_cnt;
  assign byp_cnt = cnt_next(rd_cnt, pc_src_res_e_i);

  // Prediction from the counter MSB, forwarding a same-entry update in flight.
  always_comb begin
    pred_taken_f_o = rd_cnt[1];
    if (upd && (wr_bank == rd_bank) && (wr_idx == rd_idx)) begin
      pred_taken_f_o = byp_cnt[1];
    end
  end
`else
  // Prediction from the stored counter MSB; a same-cycle update is not visible yet.
  always_comb begin
    pred_taken_f_o = rd_cnt[1];
  end
`endif

endmodule

// File: tb/tb_local_pred_bank.sv
// Scoreboard bench for local_pred_bank. The driver predicts each Fetch-stage
// answer from a plain array of counter values (0..3) and queues it; a monitor
// on the falling edge pops and compares against pred_taken_f_o.
module tb_local_pred_bank;

  localparam int IB = 4;
  localparam int NE = 1 << IB;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_f_i;
  logic [1:0]  local_src_i;
  logic        pred_taken_f_o;
  logic [31:0] pc_e_i;
  logic [1:0]  local_src_e_i;
  logic [1:0]  branch_op_e_i;
  logic        pc_src_res_e_i;
  logic        stall_e_i;

  local_pred_bank #(.INDEX_BITS(IB)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .pc_f_i         (pc_f_i),
    .local_src_i    (local_src_i),
    .pred_taken_f_o (pred_taken_f_o),
    .pc_e_i         (pc_e_i),
    .local_src_e_i  (local_src_e_i),
    .branch_op_e_i  (branch_op_e_i),
    .pc_src_res_e_i (pc_src_res_e_i),
    .stall_e_i      (stall_e_i)
  );

  always #5 clk_i = ~clk_i;

  int    model [4][NE];
  bit    exp_q[$];
  string name_q[$];
  bit    chk_pending = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[IB+1:2]);
  endfunction

  function automatic int trained(input int v, input logic taken);
    if (taken) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < NE; e++)
        model[b][e] = 1;
  endtask

  // Apply inputs and queue the prediction the model says Fetch should see now.
  task automatic drive(input logic [31:0] pcf, input logic [1:0] srcf,
                       input logic [31:0] pce, input logic [1:0] srce,
                       input logic [1:0] bop, input logic res, input logic stall,
                       input string nm);
    int v;
    bit e;
    bit upd;
    pc_f_i         = pcf;
    local_src_i    = srcf;
    pc_e_i         = pce;
    local_src_e_i  = srce;
    branch_op_e_i  = bop;
    pc_src_res_e_i = res;
    stall_e_i      = stall;
    upd = bop[0] && !stall;
    v = model[srcf][idx_of(pcf)];
    e = (v >= 2);
`ifdef PRED_BYPASS_EN
    if (upd && srce == srcf && idx_of(pce) == idx_of(pcf))
      e = (trained(v, res) >= 2);
`endif
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_pending = 1'b1;
  endtask

  task automatic step(input logic [31:0] pcf, input logic [1:0] srcf,
                      input logic [31:0] pce, input logic [1:0] srce,
                      input logic [1:0] bop, input logic res, input logic stall,
                      input string nm);
    drive(pcf, srcf, pce, srce, bop, res, stall, nm);
    @(posedge clk_i);
    #1;
    chk_pending = 1'b0;
    if (bop[0] && !stall)
      model[srce][idx_of(pce)] = trained(model[srce][idx_of(pce)], res);
  endtask

  task automatic read(input logic [31:0] pcf, input logic [1:0] srcf, input string nm);
    step(pcf, srcf, $urandom, $urandom_range(0, 3), 2'b10, $urandom_range(0, 1), 1'b0, nm);
  endtask

  task automatic sweep(input string nm);
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < NE; e++)
        read({$urandom_range(0, 255), 4'(e), 2'($urandom_range(0, 3))} |
             ($urandom & 32'hFFFF_C000), 2'(b), nm);
  endtask

  task automatic random_ops(input int n);
    logic [31:0] pcf, pce;
    logic [1:0]  sf, se;
    for (int i = 0; i < n; i++) begin
      pcf = $urandom;
      sf  = 2'($urandom_range(0, 3));
      pce = $urandom;
      se  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        pce = pcf;
        se  = sf;
      end
      step(pcf, sf, pce, se, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), "random");
    end
  endtask

  // Pop one expectation per presented Fetch result and compare.
  always @(negedge clk_i) begin
    if (chk_pending) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: got pred=%0b with nothing expected", pred_taken_f_o);
      end else begin
        bit    e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (pred_taken_f_o !== e) begin
          n_fail++;
          $display("FAIL %s: t=%0t pred_taken got %b expected %0b", nm, $time, pred_taken_f_o, e);
        end
      end
    end
  end

  initial begin
    reset_i        = 1'b1;
    pc_f_i         = '0;
    local_src_i    = '0;
    pc_e_i         = '0;
    local_src_e_i  = '0;
    branch_op_e_i  = '0;
    pc_src_res_e_i = 1'b0;
    stall_e_i      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    sweep("reset_state");

    // Saturate up at bank 2 index 4, then check the other banks stay WU.
    repeat (3) step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b1, 1'b0, "sat_up");
    read(32'h10, 2'd2, "sat_up_read");
    read(32'h10, 2'd0, "other_bank0");
    read(32'h10, 2'd1, "other_bank1");
    read(32'h10, 2'd3, "other_bank3");

    // Saturate down from ST.
    repeat (4) step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b0, 1'b0, "sat_down");
    read(32'h10, 2'd2, "sat_down_read");

    // Stall and non-conditional masking, then a single update on release.
    step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b1, 1'b1, "stall_hold");
    step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b1, 1'b1, "stall_hold");
    step(32'h10, 2'd2, 32'h10, 2'd2, 2'b10, 1'b1, 1'b0, "non_cond");
    read(32'h10, 2'd2, "masked_read");
    step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b1, 1'b0, "stall_release");
    step(32'h10, 2'd2, 32'h10, 2'd2, 2'b01, 1'b1, 1'b0, "one_more_up");
    read(32'h10, 2'd2, "release_read");

    // Same-cycle read/write of a WU entry.
    step(32'h24, 2'd1, 32'h24, 2'd1, 2'b01, 1'b1, 1'b0, "same_cycle");
    read(32'h24, 2'd1, "same_cycle_next");

    random_ops(400);

    // Asynchronous reset landing between edges while an update is pending.
    for (int k = 0; k < 3; k++) begin
      logic [1:0] sf;
      logic [31:0] pce;
      logic [1:0] se;
      pce = $urandom;
      se  = 2'($urandom_range(0, 3));
      sf  = se + 2'd1;
      pc_e_i = pce; local_src_e_i = se; branch_op_e_i = 2'b01;
      pc_src_res_e_i = 1'b1; stall_e_i = 1'b0;
      #2;
      reset_i = 1'b1;
      model_reset();
      drive($urandom, sf, pce, se, 2'b01, 1'b1, 1'b0, "reset_mid_op");
      @(posedge clk_i);
      #1;
      chk_pending = 1'b0;
      reset_i = 1'b0;
      sweep("reset_mid_op_sweep");
      random_ops(100);
    end

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
